// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
// Optional signed mode is selected in the top module by SEQ_MULT_SIGNED_EN.
package seq_shift_add_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MULTIPLY,
    READY
  } mult_state_t;

  localparam int MULT_DW_DEFAULT = 16;

  // Bit-counter width for a DW-step multiply; a 1-bit counter is the floor.
  function automatic int mult_cnt_width(input int dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

endpackage

// File: rtl/seq_shift_add_multiplier_if.sv
// Request/result bundle between a multiply requester (master) and the multiplier (slave).
interface seq_shift_add_multiplier_if
  import seq_shift_add_multiplier_pkg::*;
#(
  parameter int DW = MULT_DW_DEFAULT
) ();

  logic              start;
  logic [DW-1:0]     multiplicand;
  logic [DW-1:0]     multiplier;
  logic [2*DW-1:0]   product;
  logic              busy;
  logic              ready;
  logic              done;

  modport master (
    output start,
    output multiplicand,
    output multiplier,
    input  product,
    input  busy,
    input  ready,
    input  done
  );

  modport slave (
    input  start,
    input  multiplicand,
    input  multiplier,
    output product,
    output busy,
    output ready,
    output done
  );

endinterface

// File: rtl/seq_shift_add_multiplier_mult_bit_counter.sv
// Step counter for the multiplier: cleared on an accepted start, counts while
// enabled, and wraps to 0 after its terminal value DW-1.
module mult_bit_counter
  import seq_shift_add_multiplier_pkg::*;
#(
  parameter int DW = MULT_DW_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic terminal
);

  localparam int CNT_W = mult_cnt_width(DW);

  logic [CNT_W-1:0] count;

  assign terminal = (count == CNT_W'(DW - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of block ordering in simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= terminal ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-add multiplier: one multiplier bit per clock, DW-cycle latency,
// held product with ready/done. Define SEQ_MULT_SIGNED_EN for two's-complement operands.
module seq_shift_add_multiplier
  import seq_shift_add_multiplier_pkg::*;
#(
  parameter int DW = MULT_DW_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  seq_shift_add_multiplier_if.slave  bus
);

  localparam int PW = 2 * DW;

  mult_state_t      state;
  logic [DW-1:0]    a_q;
  logic [DW-1:0]    b_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    product_q;
  logic             busy_q;
  logic             ready_q;
  logic             done_q;

  logic             accept;
  logic             last_step;
  logic [DW-1:0]    a_load;
  logic [DW-1:0]    b_load;
  logic [DW-1:0]    addend;
  logic [DW:0]      sum;
  logic [PW-1:0]    acc_next;
  logic [PW-1:0]    result;
  logic             unused_acc_lsb;

`ifdef SEQ_MULT_SIGNED_EN
  logic             sign_q;
  logic             sign_load;
`endif

  assign accept = bus.start && ((state == IDLE) || (state == READY));

  mult_bit_counter #(
    .DW (DW)
  ) u_bit_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .en       (state == MULTIPLY),
    .terminal (last_step)
  );

  // Operand conditioning at acceptance; magnitudes fit DW bits even for -2^(DW-1).
`ifdef SEQ_MULT_SIGNED_EN
  always_comb begin
    a_load    = bus.multiplicand;
    b_load    = bus.multiplier;
    sign_load = bus.multiplicand[DW-1] ^ bus.multiplier[DW-1];
    if (bus.multiplicand[DW-1]) a_load = ~bus.multiplicand + 1'b1;
    if (bus.multiplier[DW-1])   b_load = ~bus.multiplier + 1'b1;
  end
`else
  assign a_load = bus.multiplicand;
  assign b_load = bus.multiplier;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned, which would infer a latch.
  always_comb begin
    addend = '0;
    if (b_q[0]) addend = a_q;
    sum      = {1'b0, acc_q[PW-1:DW]} + {1'b0, addend};
    acc_next = {sum, acc_q[DW-1:1]};
  end

  // The bit shifted out of the accumulator each step is discarded by design.
  assign unused_acc_lsb = acc_q[0];

`ifdef SEQ_MULT_SIGNED_EN
  assign result = sign_q ? (~acc_next + 1'b1) : acc_next;
`else
  assign result = acc_next;
`endif

  // NOTE: the asynchronous reset clears every register, operands and
  // accumulator included, so an aborted multiply leaves no residue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
      sign_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, READY: begin
          if (bus.start) begin
            a_q     <= a_load;
            b_q     <= b_load;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            state   <= MULTIPLY;
`ifdef SEQ_MULT_SIGNED_EN
            sign_q  <= sign_load;
`endif
          end
        end
        MULTIPLY: begin
          acc_q <= acc_next;
          b_q   <= b_q >> 1;
          if (last_step) begin
            product_q <= result;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b1;
            state     <= READY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.product = product_q;
  assign bus.busy    = busy_q;
  assign bus.ready   = ready_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier at DW=8: timeline model plus
// directed vectors with literal expectations (signed vectors under SEQ_MULT_SIGNED_EN).
module tb_seq_shift_add_multiplier;

  localparam int DW = 8;
  localparam int PW = 2 * DW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_shift_add_multiplier_if #(.DW(DW)) bus ();

  seq_shift_add_multiplier #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Arithmetic reference: the exact product truncated to PW bits.
  function automatic logic [PW-1:0] ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint pa, pb;
`ifdef SEQ_MULT_SIGNED_EN
    pa = longint'($signed(a));
    pb = longint'($signed(b));
`else
    pa = longint'(a);
    pb = longint'(b);
`endif
    return PW'(pa * pb);
  endfunction

  // Timeline model: a request accepted while idle yields its product DW edges later.
  int             m_left;
  logic [PW-1:0]  m_pend;
  logic [PW-1:0]  m_prod;
  logic           m_ready;
  logic           m_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0; m_pend = '0; m_prod = '0; m_ready = 1'b0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_prod = m_pend; m_ready = 1'b1; m_done = 1'b1;
        end
      end else if (bus.start) begin
        m_pend  = ref_mul(bus.multiplicand, bus.multiplier);
        m_left  = DW;
        m_ready = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc product", bus.product, m_prod);
      check("cyc busy",    bus.busy,    m_left > 0);
      check("cyc ready",   bus.ready,   m_ready);
      check("cyc done",    bus.done,    m_done);
    end
  end

  task automatic pulse_start(input logic [DW-1:0] a, input logic [DW-1:0] b);
    @(negedge clk); #1;
    bus.start = 1'b1; bus.multiplicand = a; bus.multiplier = b;
    @(negedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    bit seen = 1'b0;
    cycles = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      cycles++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    if (!seen) check("done timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  c;
    bit  seen;
    bus.start = 1'b0; bus.multiplicand = '0; bus.multiplier = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("reset product", bus.product, 64'd0);
    check("reset busy",    bus.busy,    64'd0);
    check("reset ready",   bus.ready,   64'd0);
    check("reset done",    bus.done,    64'd0);
    @(negedge clk); #1 rst = 1'b0;
    cmp_en = 1'b1;

    // 13 x 11 with latency and hold
    pulse_start(8'd13, 8'd11);
    wait_done(c);
    check("latency 13x11", c, DW);
    check("product 13x11", bus.product, 16'h008F);
    repeat (3) @(negedge clk);
    check("hold ready", bus.ready, 1'b1);
    check("hold done",  bus.done,  1'b0);
    check("hold product", bus.product, 16'h008F);

    pulse_start(8'd255, 8'd255);
    wait_done(c);
`ifdef SEQ_MULT_SIGNED_EN
    check("product -1x-1", bus.product, 16'h0001);
`else
    check("product 255x255", bus.product, 16'hFE01);
`endif

    pulse_start(8'd0, 8'd200);
    wait_done(c);
    check("latency 0x200", c, DW);
    check("product 0x200", bus.product, 16'h0000);

    // start during MULTIPLY is ignored
    pulse_start(8'd9, 8'd10);
    @(negedge clk); #1;
    bus.start = 1'b1; bus.multiplicand = 8'd5; bus.multiplier = 8'd5;
    @(negedge clk); #1 bus.start = 1'b0;
    wait_done(c);
    check("ignored restart", bus.product, 16'd90);

    // restart from READY
    pulse_start(8'd7, 8'd6);
    check("ready drops", bus.ready, 1'b0);
    check("old product kept", bus.product, 16'd90);
    wait_done(c);
    check("latency 7x6", c, DW);
    check("product 7x6", bus.product, 16'd42);

    // async reset mid-multiply
    pulse_start(8'd100, 8'd3);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort product", bus.product, 64'd0);
    check("abort busy",    bus.busy,    64'd0);
    check("abort ready",   bus.ready,   64'd0);
    check("abort done",    bus.done,    64'd0);
    #1 rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check("no done after abort", seen, 1'b0);
    pulse_start(8'd3, 8'd4);
    wait_done(c);
    check("product 3x4", bus.product, 16'd12);

    // start held high: one result every DW+1 cycles
    @(negedge clk); #1;
    bus.start = 1'b1; bus.multiplicand = 8'd2; bus.multiplier = 8'd9;
    wait_done(c);
    check("held product 1", bus.product, 16'd18);
    wait_done(c);
    check("held period 1", c, DW + 1);
    check("held product 2", bus.product, 16'd18);
    wait_done(c);
    check("held period 2", c, DW + 1);
    #1 bus.start = 1'b0;

`ifdef SEQ_MULT_SIGNED_EN
    pulse_start(8'hFD, 8'd5);
    wait_done(c);
    check("product -3x5", bus.product, 16'hFFF1);
    pulse_start(8'h80, 8'h80);
    wait_done(c);
    check("product -128x-128", bus.product, 16'h4000);
    pulse_start(8'h80, 8'h7F);
    wait_done(c);
    check("product -128x127", bus.product, 16'hC080);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_shift_add_multiplier.md
Name: seq_shift_add_multiplier

Overview:
Parametrised sequential shift-add multiplier. It merges the multiply control FSM, bit counter, and accumulator datapath into one block. Operands are latched on an accepted start; one multiplier bit is processed per clock; a held product is presented with a ready/done handshake. It replaces the fixed-width control unit plus external counter arrangement in the arithmetic path.

Parameters:
DW, 16, operand width in bits (legal range 2..32); product width is 2*DW.
CNT_W, $clog2(DW), localparam; bit-counter width, derived, not overridable.

Ports:
clk  input  1  system clock, rising-edge active.
rst  input  1  asynchronous reset, active-high; clears all state immediately.
start  input  1  request a multiply; sampled only in IDLE or READY.
multiplicand  input  DW  operand A; sampled on the accepted-start edge only.
multiplier  input  DW  operand B; sampled on the accepted-start edge only.
product  output  2*DW  result; registered, held stable in READY.
busy  output  1  high while a multiply is in progress (MULTIPLY state).
ready  output  1  high in READY; product valid.
done  output  1  one-cycle pulse on the first READY cycle.

Behaviour:
- Reset (rst=1, async): state=IDLE, product=0, busy=0, ready=0, done=0, counter=0, accumulator=0, operand registers=0.
- All outputs are registered; no combinational input-to-output path.
- FSM states (shared enum): IDLE, MULTIPLY, READY.
- IDLE, start=1: latch A and B, clear the accumulator, counter=0, go to MULTIPLY, busy=1 next cycle. start=0: stay.
- MULTIPLY, each cycle:
  - if B_reg[0]=1, acc_hi = acc_hi + A_reg, with the carry kept in the 2*DW accumulator;
  - then shift {carry,acc} right by 1 and B_reg right by 1;
  - counter increments.
- MULTIPLY exit: when counter==DW-1 at a clock edge, the final step completes, product<=acc result, go to READY, busy=0, ready=1, done=1 for that one cycle.
- Latency: start accepted at edge k; ready and done high after edge k+DW. Constant, independent of operand values; no early termination.
- READY: product and ready hold until a new start is accepted. done is high only on the first READY cycle.
- READY, start=1: same as IDLE acceptance. ready drops on the next edge, product keeps its old value until the new result lands, and a back-to-back restart is allowed.
- start during MULTIPLY: ignored entirely; operands are not resampled and there is no queueing.
- start held high continuously: a new multiply starts every DW+1 cycles; done pulses once per result.
- Counter wrap: the counter never exceeds DW-1 and is reset to 0 on each accepted start.
- Reset mid-MULTIPLY: the operation is aborted, all outputs return to reset values, and no done pulse is issued.
- Arithmetic: unsigned; A and B are in range 0..2^DW-1; the product is exact in 2*DW bits with no overflow possible.

Optional Feature:
Macro SEQ_MULT_SIGNED_EN.
- Defined: operands are two's complement. At acceptance, |A| and |B| are latched, plus sign = A[DW-1]^B[DW-1]. On the final step, product <= sign ? -mag : mag, in the same edge with no extra latency. -2^(DW-1) must be handled (its magnitude 2^(DW-1) fits in DW unsigned bits).
- Not defined: pure unsigned behaviour as above, with no sign logic synthesised.

Decomposition:
- Package Parameter_Definitions gains:
  - typedef enum logic [1:0] mult_state_t {IDLE, MULTIPLY, READY};
  - localparam MULT_DW_DEFAULT = 16.
- Sub-module mult_bit_counter: CNT_W-bit up-counter with sync clear on accepted start, enable in MULTIPLY, and a registered-free terminal flag (count==DW-1). It is the parametrised successor of the external counter_Flag source.
- FSM and datapath remain in the top module.

Test Plan:
- DW=8, A=13, B=11, start pulse at edge 0 -> busy for 8 cycles; at edge 8: ready=1, done=1 for one cycle, product=143 (0x008F), held while start=0.
- DW=8, A=255, B=255 -> product=65025 (0xFE01); A=0, B=200 -> product=0 with the same 8-cycle latency.
- DW=8: start re-pulsed with A=5, B=5 on cycle 3 of busy -> ignored, product is the original result. Then start in READY with A=7, B=6 -> ready drops next cycle, product becomes 42 eight edges later.
- DW=8: rst asserted asynchronously mid-MULTIPLY (between edges) -> outputs go to 0 immediately with no done pulse. Next start with A=3, B=4 -> product=12.
- DW=8, start held high with A=2, B=9 -> done pulses every 9 cycles, product=18 each time.
- SEQ_MULT_SIGNED_EN, DW=8:
  - A=-3 (0xFD), B=5 -> product=0xFFF1 (-15);
  - A=-128, B=-128 -> product=0x4000 (16384);
  - A=-128, B=127 -> product=0xC080 (-16256).
